// File: rtl/decoder_pkg.sv
// Shared definitions for the 3-to-8 decoder and its scan controller.
// Provides the select width, channel count, dwell-count width and the
// scan controller state encoding.
package decoder_pkg;

    localparam int N_SEL   = 3;
    localparam int NUM_CH  = 2 ** N_SEL;
    localparam int DWELL_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } scan_state_e;

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between the control logic (master) and the scan
// controller (slave).
//   start, stop, mode_cont, ch_mask, dwell : master -> slave control
//   sel, sel_valid, step, busy, done       : slave -> master status/select
//   state_dbg                              : slave -> master, current FSM state
// Handshake: start and stop are level inputs with no ready; start is taken
// only when the controller is idle and stop only while it is scanning. step
// and done are single-cycle pulses and carry no backpressure.
interface decoder_scan_ctrl_if;
    import decoder_pkg::*;

    logic                start;
    logic                stop;
    logic                mode_cont;
    logic [NUM_CH-1:0]   ch_mask;
    logic [DWELL_W-1:0]  dwell;
    logic [N_SEL-1:0]    sel;
    logic                sel_valid;
    logic                step;
    logic                busy;
    logic                done;
    scan_state_e         state_dbg;

    modport master (
        output start, stop, mode_cont, ch_mask, dwell,
        input  sel, sel_valid, step, busy, done, state_dbg
    );

    modport slave (
        input  start, stop, mode_cont, ch_mask, dwell,
        output sel, sel_valid, step, busy, done, state_dbg
    );

endinterface

// File: rtl/decoder_scan_ctrl_scan_next_ch.sv
// Combinational channel search for the scan controller.
//   ch_mask     : enabled channels
//   cur         : currently selected channel
//   nxt_above   : lowest enabled channel strictly above cur (valid when found_above)
//   found_above : such a channel exists
//   nxt_lowest  : lowest enabled channel overall (valid when any)
//   any         : at least one channel enabled
module scan_next_ch
    import decoder_pkg::*;
(
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [N_SEL-1:0]  cur,
    output logic [N_SEL-1:0]  nxt_above,
    output logic              found_above,
    output logic [N_SEL-1:0]  nxt_lowest,
    output logic              any
);

    // Walk from the top down so the last hit written is the lowest index.
    always_comb begin
        nxt_above   = '0;
        found_above = 1'b0;
        nxt_lowest  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                nxt_lowest = N_SEL'(i);
                if (i > int'(cur)) begin
                    nxt_above   = N_SEL'(i);
                    found_above = 1'b1;
                end
            end
        end
    end

    assign any = |ch_mask;

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan controller for the 3-to-8 decoder. Steps the select code {A,B,C}
// through the enabled channels, holding each for dwell+1 cycles, in single
// pass or continuous mode, with start/stop control.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : control inputs and registered select/status outputs
module decoder_scan_ctrl
    import decoder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    decoder_scan_ctrl_if.slave   bus
);

    scan_state_e        state_q, state_d;
    logic [N_SEL-1:0]   sel_q, sel_d;
    logic               sel_valid_q, sel_valid_d;
    logic               step_q, step_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    logic [N_SEL-1:0]   nxt_above;
    logic               found_above;
    logic [N_SEL-1:0]   nxt_lowest;
    logic               any;

    scan_next_ch u_next (
        .ch_mask     (bus.ch_mask),
        .cur         (sel_q),
        .nxt_above   (nxt_above),
        .found_above (found_above),
        .nxt_lowest  (nxt_lowest),
        .any         (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            step_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            step_q      <= step_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        step_d      = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                // stop is deliberately not looked at here.
                if (bus.start) begin
                    if (any) begin
                        state_d     = ST_DWELL;
                        sel_d       = nxt_lowest;
                        sel_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        step_d      = 1'b1;
                        cnt_d       = bus.dwell;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_DWELL: begin
                if (bus.stop) begin
                    // Abort wins even over an advance in the same cycle.
                    state_d     = ST_IDLE;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (found_above) begin
                    sel_d  = nxt_above;
                    step_d = 1'b1;
                    cnt_d  = bus.dwell;
                end else if (bus.mode_cont && any) begin
                    // Wrap; may re-select the same channel if it is the only one.
                    sel_d  = nxt_lowest;
                    step_d = 1'b1;
                    cnt_d  = bus.dwell;
                end else begin
                    // Pass complete or mask emptied: sel keeps its last value.
                    state_d     = ST_IDLE;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.step      = step_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;

endmodule
